// File: rtl/id_fetch_rx_pkg.sv
// id_fetch_rx_pkg: shared fetch-bus field layout and constants for fetch and decode
package id_fetch_rx_pkg;

    localparam int PC_W    = 32;
    localparam int INST_W  = 32;
    localparam int BUS_W   = PC_W + INST_W;

    localparam int PC_HI   = 63;
    localparam int PC_LO   = 32;
    localparam int INST_HI = 31;
    localparam int INST_LO = 0;

    // addi x0,x0,0 presented to decode when no packet is buffered
    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

    // A PC is misaligned when its low two bits are not zero
    function automatic logic pc_misaligned(input logic [1:0] lo);
        return lo != 2'b00;
    endfunction

endpackage

// File: rtl/id_fetch_rx_fifo_ctrl.sv
// id_fetch_rx_fifo_ctrl: read/write pointers, entry count and full/empty flags for the receive FIFO
module id_fetch_rx_fifo_ctrl
    import id_fetch_rx_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    output logic [AW-1:0] rd_ptr,
    output logic [AW-1:0] wr_ptr,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    // Flush wins over any push or pop; pointers wrap naturally at their width
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/id_fetch_rx.sv
// id_fetch_rx: decode-side skid FIFO for {PC, Inst} fetch packets with redirect flush
module id_fetch_rx #(
    parameter int                DEPTH    = 2,
    parameter int                PC_W     = id_fetch_rx_pkg::PC_W,
    parameter int                INST_W   = id_fetch_rx_pkg::INST_W,
    parameter logic [INST_W-1:0] NOP_INST = id_fetch_rx_pkg::NOP_INST
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PC_W+INST_W-1:0]   in_bus,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PC_W-1:0]          out_pc,
    output logic [INST_W-1:0]        out_inst,
    output logic                     out_misalign,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   occupancy
);
    import id_fetch_rx_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [PC_W-1:0]   pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [CW-1:0]     count;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    // Ready comes only from registered state and flush, so no path from out_ready
    assign in_ready  = ~full & ~flush;
    assign out_valid = ~empty;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    id_fetch_rx_fifo_ctrl #(
        .DEPTH (DEPTH)
    ) u_ctrl (
        .clk    (clk),
        .reset  (reset),
        .push   (push),
        .pop    (pop),
        .flush  (flush),
        .rd_ptr (rd_ptr),
        .wr_ptr (wr_ptr),
        .count  (count),
        .full   (full),
        .empty  (empty)
    );

    // Entry storage; flush leaves contents in place since count gates visibility
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                inst_mem[i] <= '0;
            end
        end else if (push) begin
            pc_mem[wr_ptr]   <= in_bus[PC_W+INST_W-1:INST_W];
            inst_mem[wr_ptr] <= in_bus[INST_W-1:0];
        end
    end

    // Head presentation: NOP substituted when empty, misalign qualified by valid
    always_comb begin
        out_pc       = pc_mem[rd_ptr];
        out_inst     = out_valid ? inst_mem[rd_ptr] : NOP_INST;
        out_misalign = out_valid & pc_misaligned(out_pc[1:0]);
        occupancy    = count;
    end

endmodule

// File: tb/tb_id_fetch_rx.sv
// tb_id_fetch_rx: directed stimulus with a queue scoreboard checked by an independent monitor
module tb_id_fetch_rx;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        mis;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_bus = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_misalign;
    logic        flush = 1'b0;
    logic [1:0]  occupancy;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    id_fetch_rx dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_bus       (in_bus),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_inst     (out_inst),
        .out_misalign (out_misalign),
        .flush        (flush),
        .occupancy    (occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] inst, input logic mis, input logic accept);
        in_valid = 1'b1;
        in_bus   = {pc, inst};
        if (accept)
            q.push_back('{pc: pc, inst: inst, mis: mis});
    endtask

    // Monitor: compares each popped head against the scoreboard, and idle outputs against NOP
    always @(negedge clk) begin
        if (reset) begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_pop", 64'(out_pc), 64'hdead);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("sb_pc", 64'(out_pc), 64'(e.pc));
                    check("sb_inst", 64'(out_inst), 64'(e.inst));
                    check("sb_misalign", 64'(out_misalign), 64'(e.mis));
                end
            end else if (!out_valid) begin
                check("idle_nop", 64'(out_inst), 64'(NOP));
                check("idle_misalign", 64'(out_misalign), 64'd0);
            end
        end
    end

    initial begin
        // reset held low
        #3;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_inst", 64'(out_inst), 64'(NOP));
        check("rst_occupancy", 64'(occupancy), 64'd0);
        check("rst_out_pc", 64'(out_pc), 64'd0);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        step();
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // single packet
        out_ready = 1'b1;
        drive(32'h0, 32'h0050_0093, 1'b0, 1'b1);
        step();
        in_valid = 1'b0;
        check("single_valid", 64'(out_valid), 64'd1);
        check("single_pc", 64'(out_pc), 64'd0);
        check("single_inst", 64'(out_inst), 64'h0050_0093);
        step();
        check("single_drained", 64'(out_valid), 64'd0);

        // back-pressure
        out_ready = 1'b0;
        drive(32'h0, 32'h0000_0113, 1'b0, 1'b1);
        step();
        drive(32'h4, 32'h0000_0193, 1'b0, 1'b1);
        step();
        check("bp_occupancy", 64'(occupancy), 64'd2);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        drive(32'h8, 32'h0000_0213, 1'b0, 1'b0);
        step();
        check("bp_third_rejected", 64'(occupancy), 64'd2);
        check("bp_hold_pc", 64'(out_pc), 64'd0);
        check("bp_hold_inst", 64'(out_inst), 64'h0000_0113);
        step();
        check("bp_hold_pc2", 64'(out_pc), 64'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("bp_second_head", 64'(out_pc), 64'h4);
        check("bp_full_reopen", 64'(in_ready), 64'd1);
        step();
        check("bp_drained", 64'(out_valid), 64'd0);

        // streaming
        for (int i = 0; i < 8; i++) begin
            drive(32'h100 + 32'(4 * i), 32'h0000_0093 | (32'(i) << 20), 1'b0, 1'b1);
            step();
            check("stream_occupancy", 64'(occupancy), 64'd1);
            check("stream_valid", 64'(out_valid), 64'd1);
            check("stream_pc", 64'(out_pc), 64'(32'h100 + 32'(4 * i)));
        end
        in_valid = 1'b0;
        step();
        check("stream_drained", 64'(out_valid), 64'd0);

        // flush
        out_ready = 1'b0;
        drive(32'h10, 32'h0000_0313, 1'b0, 1'b1);
        step();
        drive(32'h14, 32'h0000_0393, 1'b0, 1'b1);
        step();
        check("fl_pre_occ", 64'(occupancy), 64'd2);
        flush = 1'b1;
        drive(32'h40, 32'h0000_0413, 1'b0, 1'b0);
        q.delete();
        #1;
        check("fl_in_ready", 64'(in_ready), 64'd0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_occupancy", 64'(occupancy), 64'd0);
        check("fl_out_valid", 64'(out_valid), 64'd0);
        drive(32'h80, 32'h0000_0493, 1'b0, 1'b1);
        step();
        in_valid = 1'b0;
        check("fl_new_head_valid", 64'(out_valid), 64'd1);
        check("fl_new_head_pc", 64'(out_pc), 64'h80);
        out_ready = 1'b1;
        step();
        check("fl_drained", 64'(out_valid), 64'd0);

        // async reset mid-stream
        out_ready = 1'b0;
        drive(32'h20, 32'h0000_0513, 1'b0, 1'b1);
        step();
        in_valid = 1'b0;
        check("ar_pre_valid", 64'(out_valid), 64'd1);
        #2 reset = 1'b0;
        q.delete();
        #1;
        check("ar_valid_drop", 64'(out_valid), 64'd0);
        check("ar_occupancy", 64'(occupancy), 64'd0);
        check("ar_inst_nop", 64'(out_inst), 64'(NOP));
        #3 reset = 1'b1;
        step();
        check("ar_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        drive(32'h4, 32'h0000_0593, 1'b0, 1'b1);
        step();
        check("ar_pc4", 64'(out_pc), 64'h4);
        check("ar_pc4_mis", 64'(out_misalign), 64'd0);
        drive(32'h6, 32'h0000_0613, 1'b1, 1'b1);
        step();
        in_valid = 1'b0;
        check("ar_pc6", 64'(out_pc), 64'h6);
        check("ar_pc6_mis", 64'(out_misalign), 64'd1);
        step();
        check("ar_drained", 64'(out_valid), 64'd0);
        step();
        check("sb_empty_at_end", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_fetch_rx.md
Name: id_fetch_rx

Overview:
- Decode-side receiver for the fetch-stage data bus {PC[63:32], Inst[31:0]}.
- Accepts fetch packets over a valid/ready handshake and buffers them in a small in-order FIFO (default two entries, a skid buffer).
- Presents the head packet to decode over a second valid/ready handshake.
- Discards all buffered packets on a redirect flush from branch/jump resolution.

Parameters:
- DEPTH, 2, number of buffer entries; power of two, >= 2.
- PC_W, 32, PC field width (bus bits 63:32).
- INST_W, 32, instruction field width (bus bits 31:0).
- NOP_INST, 32'h00000013, instruction presented on out_inst while empty (addi x0,x0,0).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  fetch packet valid.
- in_ready  out  1  receiver can accept a packet this cycle.
- in_bus  in  PC_W+INST_W  {PC, Inst} from fetch.
- out_valid  out  1  head packet valid toward decode.
- out_ready  in  1  decode accepts head packet.
- out_pc  out  PC_W  head PC.
- out_inst  out  INST_W  head instruction, or NOP_INST when empty.
- out_misalign  out  1  head PC[1:0] != 0; qualified by out_valid.
- flush  in  1  redirect: drop all buffered and incoming packets.
- occupancy  out  $clog2(DEPTH)+1  current entry count.

Behaviour:
- Reset (reset low, asynchronous):
  - count = 0, rd_ptr = 0, wr_ptr = 0, entry storage = 0.
  - out_valid = 0, out_pc = 0, out_inst = NOP_INST, out_misalign = 0, occupancy = 0.
  - in_ready = 1 once reset is high.
- Handshake rules:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_ready = (count < DEPTH) & ~flush. It is derived from registers and flush only, never from out_ready, so there is no combinational ready path.
  - out_valid = (count != 0). out_valid does not depend on in_valid.
- Latency: a packet pushed at edge N is visible on out_* after edge N. There is no bypass: minimum 1-cycle latency, with full throughput of 1 packet per cycle while 0 < count < DEPTH.
- Push: store in_bus at wr_ptr; wr_ptr increments modulo DEPTH.
- Pop: rd_ptr increments modulo DEPTH.
- Count update:
  - push only: count + 1.
  - pop only: count - 1.
  - push and pop together: count unchanged, both pointers advance.
- Boundaries:
  - Full (count == DEPTH): in_ready = 0, so push is impossible. A pop in the same cycle does not reopen in_ready until the next cycle.
  - Empty: out_valid = 0; out_ready is ignored; out_inst = NOP_INST; out_pc holds the entry at rd_ptr.
  - Pointer wrap: pointers are $clog2(DEPTH) bits, so wrap is natural; count is one bit wider to distinguish full from empty.
- Flush (highest priority): on the next edge count = 0 and rd_ptr = wr_ptr = 0.
  - in_ready is already 0 during the flush cycle.
  - A simultaneous pop is still considered taken by decode but has no state effect.
  - Entry storage is not cleared.
- Data stability: a held head packet (out_valid & ~out_ready) keeps out_pc and out_inst stable until it is popped or flushed.
- Reset mid-operation: all state returns to reset values immediately (asynchronously); pending packets are lost.
- out_misalign = out_valid & (out_pc[1:0] != 2'b00).

Decomposition:
- Shared package: PC_W, INST_W, NOP_INST, and bus field offsets (PC_HI = 63, PC_LO = 32, INST_HI = 31, INST_LO = 0). The fetch stage reuses these for its bus packing.
- One sub-module: fifo_ctrl, holding pointers, count, and the full/empty logic. The top level keeps storage, flush priority and output muxing.

Test Plan:
- Reset then idle:
  - While reset is low, out_valid = 0, out_inst = 32'h00000013 and occupancy = 0.
  - After release, in_ready = 1.
- Single packet:
  - Drive in_bus = {32'h0000_0000, 32'h00500093} valid for 1 cycle with out_ready = 1.
  - Next cycle out_valid = 1, out_pc = 0, out_inst = 32'h00500093; the cycle after, out_valid = 0.
- Back-pressure:
  - With out_ready = 0, push PC 0, 4, 8.
  - After two pushes occupancy = 2 and in_ready = 0; the third packet is not accepted.
  - Raise out_ready: outputs PC 0 then 4, in order, held stable while stalled.
- Streaming:
  - Hold in_valid = 1 and out_ready = 1 for 8 cycles with PC incrementing by 4.
  - Expect 8 consecutive outputs, occupancy steady at 1, and no bubbles after the first cycle.
- Flush:
  - With 2 entries buffered (PC 0x10, 0x14), assert flush for 1 cycle together with in_valid.
  - In that cycle in_ready = 0; next cycle occupancy = 0 and out_valid = 0.
  - The next push (PC 0x80) appears as the head.
- Async reset mid-stream:
  - Drive reset low between clock edges with 1 entry buffered.
  - out_valid drops immediately without a clock edge.
  - After release, a new packet (PC 0x4) is output correctly with out_misalign = 0; PC 0x6 gives out_misalign = 1.
